ring_monitor: RTL and testbench
===============================

# ring_monitor

Receive-side checker and decoder for a one-hot ring counter bus. Each valid sample is checked for one-hot encoding and decoded to a binary index. The block also checks that the hot bit advanced exactly one position toward the LSB, with bit 0 wrapping to bit WIDTH-1. It tracks lock state, counts completed laps, and flags ring corruption. It sits on the consumer side of any ring counter in the design and feeds the status logic.

## Interface
- WIDTH, default 4: ring width in bits; legal range is WIDTH >= 2.
- IDX_W, default $clog2(WIDTH): width of the decoded index.
- LAP_W, default 8: width of the lap counter.
- RESYNC, default 2: consecutive correct steps required to declare lock; legal range is RESYNC >= 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- ring_in  in  WIDTH  sampled ring counter vector.
- ring_valid  in  1  ring_in is meaningful this cycle.
- clear_err  in  1  clears err_sticky.
- index  out  IDX_W  decoded position of the hot bit.
- index_valid  out  1  index reflects a one-hot sample taken last cycle.
- locked  out  1  ring is confirmed to be rotating correctly.
- err_pulse  out  1  one-cycle strobe for each detected fault.
- err_sticky  out  1  latched fault flag.
- lap_count  out  LAP_W  wraps observed while locked; saturating.

## Operation
- Samples with ring_valid=0 are ignored: no state change, index holds its value, index_valid=0.
- A valid sample is classified as one of:
  - ONEHOT: exactly one bit set.
  - BAD: zero bits set, or two or more bits set.
- Expected next index: exp = (prev==0) ? WIDTH-1 : prev-1.
- A step is GOOD when the sample is ONEHOT, prev_ok=1, and the decoded index == exp.
- Internal state: state, prev (IDX_W bits), prev_ok, good_cnt (range 0..RESYNC).

HUNT state:
- GOOD step: good_cnt++. When good_cnt reaches RESYNC, go to LOCKED.
- ONEHOT but not GOOD: prev=idx, prev_ok=1, good_cnt=0. No error.
- BAD: prev_ok=0, good_cnt=0. No error.

LOCKED state:
- GOOD step: stay in LOCKED. If prev==0 and idx==WIDTH-1, lap_count++, saturating at 2^LAP_W-1.
- Any other valid sample is a fault. This includes a repeated index, a skipped position, reverse direction, and BAD.
- On a fault:
  - err_pulse=1 and err_sticky=1.
  - State goes to HUNT with good_cnt=0.
  - If the faulting sample is ONEHOT: prev=idx and prev_ok=1. If BAD: prev_ok=0.

Common rules:
- On every ONEHOT valid sample, prev is updated to idx, and the registered index is updated to idx.
- err_sticky clears on clear_err. If a fault and clear_err occur in the same cycle, the set wins.
- lap_count clears only on reset. Losing lock does not clear it.

## Timing
- All outputs are registered. Latency is 1 cycle: a sample at edge N is reflected in the outputs after edge N+1.
- index_valid = registered (ring_valid && ONEHOT).
- locked rises on the same edge that registers the RESYNC-th GOOD step.
- locked falls on the same edge that registers a fault, coincident with err_pulse.
- err_pulse is high for exactly one cycle per faulting sample. Back-to-back faults can only occur from HUNT, which never faults, so err_pulse cannot be high on consecutive cycles.
- Reset values: state=HUNT, prev=0, prev_ok=0, good_cnt=0, index=0, index_valid=0, locked=0, err_pulse=0, err_sticky=0, lap_count=0.
- Reset asserted mid-lock returns every output to its reset value on the next edge. Reset overrides all inputs, including clear_err.

## Test plan
All scenarios use WIDTH=4 and RESYNC=2.
- Lock and lap: reset, then valid samples 1000, 0100, 0010, 0001, 1000 on consecutive cycles.
  - Required: index=3,2,1,0,3 with index_valid=1.
  - locked=1 after the 0010 sample.
  - lap_count=1 after the final 1000 sample.
  - err_pulse never asserts.
- Corruption while locked: after lock, drive 0110.
  - Required: err_pulse=1 for one cycle, err_sticky=1, locked=0, index_valid=0.
  - Then drive 0100, 0010, 0001: locked=1 again after 0001, because 0100 loads prev and the next two steps are GOOD.
- Skip and stall while locked:
  - 0100 followed by 0001 gives a fault, with index=0.
  - Re-lock, then repeat 0010 twice: the second 0010 is a fault.
- Valid gaps: while locked, hold ring_valid=0 for 3 cycles between 0100 and 0010.
  - Required: index_valid=0 during the gap, index held at 2, locked stays 1, no error after 0010.
- Clear priority:
  - clear_err together with a fault: err_sticky stays 1.
  - clear_err alone: err_sticky=0 next cycle.
  - With LAP_W=2 and 5 full laps: lap_count saturates at 3.
- Reset mid-operation: assert reset while locked with lap_count=2.
  - Required: all outputs at their reset values after one edge.
  - Then 0001, 1000, 0100 gives locked=1 and lap_count=0. The 0001 to 1000 wrap occurs in HUNT, so it is not counted.

Source files
------------

// File: rtl/ring_monitor_if.sv
// Bus between a one-hot ring counter producer and its ring_monitor checker.
// The producer side drives the sample; the monitor returns decoded status.
interface ring_monitor_if #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH),
  parameter int LAP_W = 8
);
  logic [WIDTH-1:0] ring_in;
  logic             ring_valid;
  logic             clear_err;
  logic [IDX_W-1:0] index;
  logic             index_valid;
  logic             locked;
  logic             err_pulse;
  logic             err_sticky;
  logic [LAP_W-1:0] lap_count;

  modport master (
    output ring_in, ring_valid, clear_err,
    input  index, index_valid, locked, err_pulse, err_sticky, lap_count
  );

  modport slave (
    input  ring_in, ring_valid, clear_err,
    output index, index_valid, locked, err_pulse, err_sticky, lap_count
  );
endinterface

// File: rtl/ring_monitor.sv
// Receive-side checker for a one-hot ring counter rotating toward the LSB:
// decodes the hot bit, confirms lock, counts laps and flags corruption.
module ring_monitor #(
  parameter int WIDTH  = 4,
  parameter int IDX_W  = $clog2(WIDTH),
  parameter int LAP_W  = 8,
  parameter int RESYNC = 2
) (
  input logic          clk,
  input logic          reset,
  ring_monitor_if.slave bus
);

  localparam int CNT_W = $clog2(RESYNC + 1);

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] prev_q;
  logic             prev_ok_q;
  logic [CNT_W-1:0] good_cnt_q;
  logic [IDX_W-1:0] index_q;
  logic             index_valid_q;
  logic             locked_q;
  logic             err_pulse_q;
  logic             err_sticky_q;
  logic [LAP_W-1:0] lap_q;

  logic [IDX_W-1:0] sample_idx;
  logic [IDX_W-1:0] exp_idx;
  logic             one_hot;
  logic             good_step;
  logic             lap_wrap;
  logic             fault;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sample_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.ring_in[i]) sample_idx = IDX_W'(i);
    end
  end

  assign one_hot   = $onehot(bus.ring_in);
  assign exp_idx   = (prev_q == '0) ? IDX_W'(WIDTH - 1) : prev_q - IDX_W'(1);
  assign good_step = bus.ring_valid && one_hot && prev_ok_q && (sample_idx == exp_idx);
  assign lap_wrap  = (prev_q == '0) && (sample_idx == IDX_W'(WIDTH - 1));
  // Only a locked ring can fault; hunting silently re-acquires.
  assign fault     = bus.ring_valid && (state_q == LOCKED) && !good_step;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      prev_q        <= '0;
      prev_ok_q     <= 1'b0;
      good_cnt_q    <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_sticky_q  <= 1'b0;
      lap_q         <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (bus.ring_valid) begin
        index_valid_q <= one_hot;
        prev_ok_q     <= one_hot;
        if (one_hot) begin
          prev_q  <= sample_idx;
          index_q <= sample_idx;
        end
        case (state_q)
          HUNT: begin
            if (good_step) begin
              if (good_cnt_q == CNT_W'(RESYNC - 1)) begin
                state_q    <= LOCKED;
                locked_q   <= 1'b1;
                good_cnt_q <= '0;
              end else begin
                good_cnt_q <= good_cnt_q + CNT_W'(1);
              end
            end else begin
              good_cnt_q <= '0;
            end
          end
          LOCKED: begin
            if (good_step) begin
              if (lap_wrap && !(&lap_q)) lap_q <= lap_q + LAP_W'(1);
            end else begin
              err_pulse_q <= 1'b1;
              state_q     <= HUNT;
              locked_q    <= 1'b0;
              good_cnt_q  <= '0;
            end
          end
          default: state_q <= HUNT;
        endcase
      end else begin
        index_valid_q <= 1'b0;
      end
      // A fault in the same cycle as clear_err keeps the flag set.
      if (fault) begin
        err_sticky_q <= 1'b1;
      end else if (bus.clear_err) begin
        err_sticky_q <= 1'b0;
      end
    end
  end

  assign bus.index       = index_q;
  assign bus.index_valid = index_valid_q;
  assign bus.locked      = locked_q;
  assign bus.err_pulse   = err_pulse_q;
  assign bus.err_sticky  = err_sticky_q;
  assign bus.lap_count   = lap_q;

endmodule

// File: tb/tb_ring_monitor.sv
// Self-checking bench for ring_monitor: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_ring_monitor;
  localparam int W = 4;
  localparam int R = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] ring_in;
  logic         ring_valid;
  logic         clear_err;

  always #5 clk = ~clk;

  ring_monitor_if #(.WIDTH(W), .LAP_W(8)) bus ();
  ring_monitor_if #(.WIDTH(W), .LAP_W(2)) bus_sat ();

  assign bus.ring_in        = ring_in;
  assign bus.ring_valid     = ring_valid;
  assign bus.clear_err      = clear_err;
  assign bus_sat.ring_in    = ring_in;
  assign bus_sat.ring_valid = ring_valid;
  assign bus_sat.clear_err  = clear_err;

  ring_monitor #(.WIDTH(W), .LAP_W(8), .RESYNC(R)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  ring_monitor #(.WIDTH(W), .LAP_W(2), .RESYNC(R)) dut_sat (
    .clk(clk), .reset(reset), .bus(bus_sat)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: plain integers, ring position arithmetic modulo W.
  int m_locked, m_prev, m_prev_ok, m_good, m_lap, m_index;
  bit m_sticky, m_pulse, m_iv;

  task automatic model_step(input logic [W-1:0] r, input bit v, input bit c, input bit rs);
    int  idx;
    bit  one, good;
    if (rs) begin
      m_locked = 0; m_prev = 0; m_prev_ok = 0; m_good = 0; m_lap = 0;
      m_index = 0; m_sticky = 0; m_pulse = 0; m_iv = 0;
      return;
    end
    m_pulse = 0;
    m_iv    = 0;
    if (v) begin
      one  = ($countones(r) == 1);
      idx  = one ? $clog2(int'(r)) : 0;
      good = one && (m_prev_ok != 0) && (idx == (m_prev + W - 1) % W);
      if (m_locked != 0) begin
        if (good) begin
          if (m_prev == 0 && idx == W - 1) m_lap++;
        end else begin
          m_pulse = 1; m_locked = 0; m_good = 0;
        end
      end else if (good) begin
        m_good++;
        if (m_good == R) begin m_locked = 1; m_good = 0; end
      end else begin
        m_good = 0;
      end
      if (one) begin
        m_prev = idx; m_index = idx; m_iv = 1; m_prev_ok = 1;
      end else begin
        m_prev_ok = 0;
      end
    end
    if (m_pulse) m_sticky = 1;
    else if (c)  m_sticky = 0;
  endtask

  task automatic cycle(input logic [W-1:0] r, input bit v, input bit c, input bit rs);
    ring_in = r; ring_valid = v; clear_err = c; reset = rs;
    @(posedge clk);
    #1;
    model_step(r, v, c, rs);
    check("index",       bus.index,       m_index);
    check("index_valid", bus.index_valid, m_iv);
    check("locked",      bus.locked,      m_locked);
    check("err_pulse",   bus.err_pulse,   m_pulse);
    check("err_sticky",  bus.err_sticky,  m_sticky);
    check("lap_count",   bus.lap_count,   (m_lap > 255) ? 255 : m_lap);
    check("lap_sat",     bus_sat.lap_count, (m_lap > 3) ? 3 : m_lap);
  endtask

  typedef struct {
    logic [W-1:0] ring;
    bit           valid;
    bit           clr;
    int           idx;
    bit           iv;
    bit           lk;
    bit           pulse;
    bit           sticky;
    int           lap;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [W-1:0] r, input bit v, input bit c, input int idx,
                     input bit iv, input bit lk, input bit p, input bit s, input int lap);
    vec_t e;
    e.ring = r; e.valid = v; e.clr = c; e.idx = idx; e.iv = iv;
    e.lk = lk; e.pulse = p; e.sticky = s; e.lap = lap;
    tbl.push_back(e);
  endtask

  initial begin
    int pos;
    logic [W-1:0] r;
    bit v, c, rs;

    reset = 1'b1; ring_in = '0; ring_valid = 1'b0; clear_err = 1'b0;

    //   ring     v  c  idx iv lk p  s  lap
    add(4'b1000, 1, 0, 3,  1, 0, 0, 0, 0);  // lock and lap
    add(4'b0100, 1, 0, 2,  1, 0, 0, 0, 0);
    add(4'b0010, 1, 0, 1,  1, 1, 0, 0, 0);
    add(4'b0001, 1, 0, 0,  1, 1, 0, 0, 0);
    add(4'b1000, 1, 0, 3,  1, 1, 0, 0, 1);
    add(4'b0110, 1, 0, 3,  0, 0, 1, 1, 1);  // corruption while locked
    add(4'b0100, 1, 0, 2,  1, 0, 0, 1, 1);
    add(4'b0010, 1, 0, 1,  1, 0, 0, 1, 1);
    add(4'b0001, 1, 0, 0,  1, 1, 0, 1, 1);
    add(4'b0000, 0, 1, 0,  0, 1, 0, 0, 1);  // clear_err alone
    add(4'b1000, 1, 0, 3,  1, 1, 0, 0, 2);
    add(4'b0100, 1, 0, 2,  1, 1, 0, 0, 2);
    add(4'b1111, 0, 0, 2,  0, 1, 0, 0, 2);  // valid gap
    add(4'b1111, 0, 0, 2,  0, 1, 0, 0, 2);
    add(4'b1111, 0, 0, 2,  0, 1, 0, 0, 2);
    add(4'b0010, 1, 0, 1,  1, 1, 0, 0, 2);
    add(4'b0001, 1, 0, 0,  1, 1, 0, 0, 2);
    add(4'b1000, 1, 0, 3,  1, 1, 0, 0, 3);
    add(4'b0100, 1, 0, 2,  1, 1, 0, 0, 3);
    add(4'b0001, 1, 0, 0,  1, 0, 1, 1, 3);  // skipped position
    add(4'b1000, 1, 0, 3,  1, 0, 0, 1, 3);
    add(4'b0100, 1, 0, 2,  1, 1, 0, 1, 3);
    add(4'b0010, 1, 0, 1,  1, 1, 0, 1, 3);
    add(4'b0010, 1, 1, 1,  1, 0, 1, 1, 3);  // stall with clear_err: set wins
    add(4'b0000, 1, 1, 1,  0, 0, 0, 0, 3);  // BAD while hunting, clear

    cycle('0, 0, 0, 1);
    foreach (tbl[i]) begin
      cycle(tbl[i].ring, tbl[i].valid, tbl[i].clr, 1'b0);
      check($sformatf("tbl%0d_index", i),  bus.index,       tbl[i].idx);
      check($sformatf("tbl%0d_iv", i),     bus.index_valid, tbl[i].iv);
      check($sformatf("tbl%0d_locked", i), bus.locked,      tbl[i].lk);
      check($sformatf("tbl%0d_pulse", i),  bus.err_pulse,   tbl[i].pulse);
      check($sformatf("tbl%0d_sticky", i), bus.err_sticky,  tbl[i].sticky);
      check($sformatf("tbl%0d_lap", i),    bus.lap_count,   tbl[i].lap);
    end

    // Reset while locked with two laps recorded.
    cycle('0, 0, 0, 1);
    pos = 3;
    repeat (10) begin
      cycle(W'(1 << pos), 1, 0, 0);
      pos = (pos + W - 1) % W;
    end
    check("pre_reset_lap",    bus.lap_count, 2);
    check("pre_reset_locked", bus.locked,    1);
    cycle(4'b0010, 1, 1, 1);
    check("rst_index",  bus.index,       0);
    check("rst_iv",     bus.index_valid, 0);
    check("rst_locked", bus.locked,      0);
    check("rst_pulse",  bus.err_pulse,   0);
    check("rst_sticky", bus.err_sticky,  0);
    check("rst_lap",    bus.lap_count,   0);
    cycle(4'b0001, 1, 0, 0);
    cycle(4'b1000, 1, 0, 0);
    cycle(4'b0100, 1, 0, 0);
    check("relock_locked", bus.locked,    1);
    check("relock_lap",    bus.lap_count, 0);

    // Five full laps: the 2-bit counter saturates, the 8-bit one keeps counting.
    cycle('0, 0, 0, 1);
    pos = 3;
    repeat (23) begin
      cycle(W'(1 << pos), 1, 0, 0);
      pos = (pos + W - 1) % W;
    end
    check("sat_lap_2bit", bus_sat.lap_count, 3);
    check("sat_lap_8bit", bus.lap_count,     5);

    // Randomized traffic: mostly correct rotation with faults, gaps and clears.
    pos = 3;
    repeat (3000) begin
      int sel;
      sel = $urandom_range(0, 99);
      v = 1'b1;
      if (sel < 65) begin
        pos = (pos + W - 1) % W;
        r   = W'(1 << pos);
      end else if (sel < 75) begin
        v = 1'b0;
        r = W'($urandom);
      end else if (sel < 85) begin
        r = W'($urandom);
      end else if (sel < 95) begin
        pos = $urandom_range(0, W - 1);
        r   = W'(1 << pos);
      end else begin
        r = W'(1 << pos);
      end
      c  = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 199) == 0);
      cycle(r, v, c, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
